// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Subtract mode (B inversion, forced carry-in) is built only when PCLA_SUB_EN is defined.
module pipelined_cla_adder #(
    parameter int WIDTH  = 12,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NG  = WIDTH / BLOCK;
    localparam int GPS = (NG + STAGES - 1) / STAGES;

    if (WIDTH % BLOCK != 0 || STAGES < 1 || STAGES > NG) begin : g_bad_cfg
        $error("pipelined_cla_adder: illegal WIDTH/BLOCK/STAGES combination");
    end

    logic             r_v  [STAGES];
    logic [WIDTH-1:0] r_s  [STAGES];
    logic [WIDTH-1:0] r_p  [STAGES];
    logic [WIDTH-1:0] r_g  [STAGES];
    logic             r_c  [STAGES];
    logic             r_ov [STAGES];

    logic             w_vi  [STAGES];
    logic [WIDTH-1:0] w_si  [STAGES];
    logic [WIDTH-1:0] w_pi  [STAGES];
    logic [WIDTH-1:0] w_gi  [STAGES];
    logic             w_ci  [STAGES];
    logic [WIDTH-1:0] w_sn  [STAGES];
    logic             w_cn  [STAGES];
    logic             w_ovn [STAGES];
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;
    logic             w_adv;
    logic [BLOCK:0]   w_gc;
    logic             w_unused;

`ifdef PCLA_SUB_EN
    assign w_bx = sub ? ~b : b;
    assign w_c0 = sub | cin;
`else
    assign w_bx = b;
    assign w_c0 = cin;
`endif
    assign w_unused = &{1'b0, sub, r_p[STAGES-1], r_g[STAGES-1]};

    assign w_adv     = ~r_v[STAGES-1] | out_ready;
    assign in_ready  = rst_n & w_adv;
    assign out_valid = r_v[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ov[STAGES-1];

    // Flat sum-of-products lookahead: every carry of the group comes straight from G/P and ci.
    function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] p, input logic [BLOCK-1:0] g,
                                           input logic ci);
        logic [BLOCK:0] c;
        logic pp, acc;
        for (int j = 0; j <= BLOCK; j++) begin
            pp  = 1'b1;
            acc = 1'b0;
            for (int m = j - 1; m >= 0; m--) begin
                acc = acc | (g[m] & pp);
                pp  = pp & p[m];
            end
            c[j] = acc | (pp & ci);
        end
        return c;
    endfunction

    always_comb begin
        w_gc    = '0;
        w_vi[0] = in_valid & in_ready;
        w_si[0] = '0;
        w_pi[0] = a ^ w_bx;
        w_gi[0] = a & w_bx;
        w_ci[0] = w_c0;
        for (int k = 1; k < STAGES; k++) begin
            w_vi[k] = r_v[k-1];
            w_si[k] = r_s[k-1];
            w_pi[k] = r_p[k-1];
            w_gi[k] = r_g[k-1];
            w_ci[k] = r_c[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_sn[k] = w_si[k];
            w_cn[k] = w_ci[k];
            for (int g = k * GPS; g < (k + 1) * GPS && g < NG; g++) begin
                w_gc = cla(w_pi[k][g*BLOCK +: BLOCK], w_gi[k][g*BLOCK +: BLOCK], w_cn[k]);
                w_sn[k][g*BLOCK +: BLOCK] = w_pi[k][g*BLOCK +: BLOCK] ^ w_gc[BLOCK-1:0];
                w_cn[k] = w_gc[BLOCK];
            end
            // Carry into the MSB is recovered as s^P there, so only the running carry is piped.
            w_ovn[k] = w_cn[k] ^ w_sn[k][WIDTH-1] ^ w_pi[k][WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]  <= 1'b0;
                r_s[k]  <= '0;
                r_p[k]  <= '0;
                r_g[k]  <= '0;
                r_c[k]  <= 1'b0;
                r_ov[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_vi[k];
                if (w_vi[k]) begin
                    r_s[k]  <= w_sn[k];
                    r_p[k]  <= w_pi[k];
                    r_g[k]  <= w_gi[k];
                    r_c[k]  <= w_cn[k];
                    r_ov[k] <= w_ovn[k];
                end
            end
        end
    end
endmodule
